// File: rtl/divider_pkg.sv
// Shared widths and the per-stage record for the pipelined restoring divider.
package divider_pkg;

    localparam int DIV_N = 8;
    localparam int DIV_M = 5;

    // One pipeline stage's register contents at the default widths
    typedef struct packed {
        logic             valid;
        logic [DIV_M:0]   partial;
        logic [DIV_N-1:0] quot;
        logic [DIV_N-1:0] dvd;
        logic [DIV_M-1:0] dvs;
    } stage_t;

endpackage

// File: rtl/divider_cell.sv
// One restoring-division stage: shift in the next dividend bit, trial-subtract,
// and register the updated partial remainder, quotient, dividend and divisor.
module divider_cell
    import divider_pkg::*;
#(
    parameter int N = DIV_N,
    parameter int M = DIV_M
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         valid_in,
    input  logic [M:0]   partial_in,
    input  logic [N-1:0] quot_in,
    input  logic [N-1:0] dvd_in,
    input  logic [M-1:0] dvs_in,
    output logic         valid_out,
    output logic [M:0]   partial_out,
    output logic [N-1:0] quot_out,
    output logic [N-1:0] dvd_out,
    output logic [M-1:0] dvs_out
);

    logic [M:0] shifted_s;
    logic [M:0] diff_s;
    logic       ge_s;
    logic [M:0] next_partial_s;

    logic         valid_r;
    logic [M:0]   partial_r;
    logic [N-1:0] quot_r;
    logic [N-1:0] dvd_r;
    logic [M-1:0] dvs_r;

    // Trial subtraction; a zero divisor always "fits", giving an all-ones quotient
    always_comb begin
        shifted_s      = {partial_in[M-1:0], dvd_in[N-1]};
        diff_s         = shifted_s - {1'b0, dvs_in};
        ge_s           = (shifted_s >= {1'b0, dvs_in});
        next_partial_s = shifted_s;
        if (ge_s) begin
            next_partial_s = diff_s;
        end else begin
            next_partial_s = shifted_s;
        end
    end

    // Stage registers: valid always advances, data only on a valid operand
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            valid_r   <= 1'b0;
            partial_r <= {(M+1){1'b0}};
            quot_r    <= {N{1'b0}};
            dvd_r     <= {N{1'b0}};
            dvs_r     <= {M{1'b0}};
        end else begin
            valid_r <= valid_in;
            if (valid_in) begin
                partial_r <= next_partial_s;
                quot_r    <= {quot_in[N-2:0], ge_s};
                dvd_r     <= {dvd_in[N-2:0], 1'b0};
                dvs_r     <= dvs_in;
            end
        end
    end

    assign valid_out   = valid_r;
    assign partial_out = partial_r;
    assign quot_out    = quot_r;
    assign dvd_out     = dvd_r;
    assign dvs_out     = dvs_r;

endmodule

// File: rtl/divider_man.sv
// Fully pipelined unsigned divider, N stages, one result per clock after N cycles.
// Define DIVIDER_ZERO_FLAG_EN to add the div_by_zero output.
module divider_man
    import divider_pkg::*;
#(
    parameter int N = DIV_N,
    parameter int M = DIV_M
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         data_rdy,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         res_rdy,
    output logic [N-1:0] merchant,
`ifdef DIVIDER_ZERO_FLAG_EN
    output logic [M-1:0] remainder,
    output logic         div_by_zero
`else
    output logic [M-1:0] remainder
`endif
);

    logic         valid_s   [N+1];
    logic [M:0]   partial_s [N+1];
    logic [N-1:0] quot_s    [N+1];
    logic [N-1:0] dvd_s     [N+1];
    logic [M-1:0] dvs_s     [N+1];

    assign valid_s[0]   = data_rdy;
    assign partial_s[0] = {(M+1){1'b0}};
    assign quot_s[0]    = {N{1'b0}};
    assign dvd_s[0]     = dividend;
    assign dvs_s[0]     = divisor;

    for (genvar k = 0; k < N; k++) begin : g_stage
        divider_cell #(
            .N (N),
            .M (M)
        ) u_cell (
            .clk         (clk),
            .rstn        (rstn),
            .valid_in    (valid_s[k]),
            .partial_in  (partial_s[k]),
            .quot_in     (quot_s[k]),
            .dvd_in      (dvd_s[k]),
            .dvs_in      (dvs_s[k]),
            .valid_out   (valid_s[k+1]),
            .partial_out (partial_s[k+1]),
            .quot_out    (quot_s[k+1]),
            .dvd_out     (dvd_s[k+1]),
            .dvs_out     (dvs_s[k+1])
        );
    end

    // Last stage registers are the outputs; the remainder never needs the guard bit
    assign res_rdy   = valid_s[N];
    assign merchant  = quot_s[N];
    assign remainder = partial_s[N][M-1:0];

`ifdef DIVIDER_ZERO_FLAG_EN
    logic [N-1:0] zero_r;

    // Zero-divisor flag travels with the valid bit; bubbles shift in 0
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            zero_r <= {N{1'b0}};
        end else begin
            zero_r <= {zero_r[N-2:0], data_rdy & (divisor == {M{1'b0}})};
        end
    end

    assign div_by_zero = zero_r[N-1];
`endif

endmodule

// File: tb/tb_divider_man.sv
// Scoreboard bench for divider_man: expectations queued at drive time, checked
// at the negedge on which they are due.
module tb_divider_man;
    import divider_pkg::*;

    localparam int N = DIV_N;
    localparam int M = DIV_M;

    logic         clk = 1'b0;
    logic         rstn;
    logic         data_rdy;
    logic [N-1:0] dividend;
    logic [M-1:0] divisor;
    logic         res_rdy;
    logic [N-1:0] merchant;
    logic [M-1:0] remainder;
`ifdef DIVIDER_ZERO_FLAG_EN
    logic         div_by_zero;
`endif

    divider_man #(.N(N), .M(M)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .data_rdy    (data_rdy),
        .dividend    (dividend),
        .divisor     (divisor),
        .res_rdy     (res_rdy),
        .merchant    (merchant),
`ifdef DIVIDER_ZERO_FLAG_EN
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
`else
        .remainder   (remainder)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] a;
        logic [M-1:0] d;
        logic [N-1:0] m;
        logic [M-1:0] r;
        logic         z;
        int           due;
    } exp_t;

    exp_t         q[$];
    int           tests = 0;
    int           fails = 0;
    int           cyc   = 0;
    logic [N-1:0] last_m = '0;
    logic [M-1:0] last_r = '0;

    task automatic check_out();
        exp_t e;
        if (res_rdy === 1'b1) begin
            tests++;
            assert (q.size() > 0 && q[0].due == cyc) else begin
                fails++;
                $error("FAIL latency: res_rdy=1 at cycle %0d, required due cycle %0d", cyc, (q.size() > 0) ? q[0].due : -1);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                assert (merchant === e.m && remainder === e.r) else begin
                    fails++;
                    $error("FAIL result %0d/%0d: got (%0d,%0d) required (%0d,%0d)", e.a, e.d, merchant, remainder, e.m, e.r);
                end
                if (e.d != '0) begin
                    tests++;
                    assert ((int'(merchant) * int'(e.d) + int'(remainder)) == int'(e.a) && remainder < e.d) else begin
                        fails++;
                        $error("FAIL invariant %0d/%0d: got q=%0d r=%0d", e.a, e.d, merchant, remainder);
                    end
                end
`ifdef DIVIDER_ZERO_FLAG_EN
                tests++;
                assert (div_by_zero === e.z) else begin
                    fails++;
                    $error("FAIL dbz_flag: got %b required %b", div_by_zero, e.z);
                end
`endif
                last_m = e.m;
                last_r = e.r;
            end
        end else begin
            tests++;
            assert (res_rdy === 1'b0 && !(q.size() > 0 && q[0].due == cyc)) else begin
                fails++;
                $error("FAIL res_rdy: got %b at cycle %0d, required 1 (result due)", res_rdy, cyc);
            end
            tests++;
            assert (merchant === last_m && remainder === last_r) else begin
                fails++;
                $error("FAIL hold: got (%0d,%0d) required (%0d,%0d)", merchant, remainder, last_m, last_r);
            end
`ifdef DIVIDER_ZERO_FLAG_EN
            tests++;
            assert (div_by_zero === 1'b0) else begin
                fails++;
                $error("FAIL dbz_idle: got %b required 0", div_by_zero);
            end
`endif
        end
    endtask

    task automatic step(input logic rdy, input logic [N-1:0] a, input logic [M-1:0] d);
        exp_t e;
        @(negedge clk);
        cyc++;
        check_out();
        data_rdy = rdy;
        dividend = a;
        divisor  = d;
        if (rdy && !rstn) begin
            e.a   = a;
            e.d   = d;
            e.z   = (d == '0);
            e.m   = (d == '0) ? {N{1'b1}} : N'(a / d);
            e.r   = (d == '0) ? a[M-1:0] : M'(a % d);
            e.due = cyc + N;
            q.push_back(e);
        end
    endtask

    initial begin
        logic [M-1:0] sweep_d [6];
        sweep_d = '{5'd7, 5'd5, 5'd3, 5'd2, 5'd4, 5'd6};
        rstn     = 1'b1;
        data_rdy = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        tests++;
        assert (res_rdy === 1'b0 && merchant === 8'd0 && remainder === 5'd0) else begin
            fails++;
            $error("FAIL reset_state: got rdy=%b q=%0d r=%0d required 0,0,0", res_rdy, merchant, remainder);
        end
        rstn = 1'b0;

        // Directed stream, boundaries and divide-by-zero, all back to back
        step(1'b1, 8'd50, 5'd14);
        step(1'b1, 8'd16, 5'd9);
        step(1'b1, 8'd10, 5'd4);
        step(1'b1, 8'd15, 5'd2);
        step(1'b1, 8'd255, 5'd1);
        step(1'b1, 8'd255, 5'd31);
        step(1'b1, 8'd0, 5'd7);
        step(1'b1, 8'd30, 5'd31);
        step(1'b1, 8'd200, 5'd0);
        step(1'b1, 8'd17, 5'd3);

        // Bubbles with junk operands on idle cycles
        for (int i = 0; i < 8; i++) begin
            step(1'(i % 2 == 0), 8'($urandom_range(255, 0)), 5'($urandom_range(31, 0)));
        end
        repeat (N + 2) step(1'b0, 8'd99, 5'd0);

        // Continuous sweeps of every dividend per divisor
        for (int s = 0; s < 6; s++) begin
            for (int a = 0; a < 256; a++) begin
                step(1'b1, 8'(a), sweep_d[s]);
            end
        end

        // Asynchronous reset with operations in flight
        for (int i = 0; i < N + 2; i++) step(1'b1, 8'(i * 37 + 11), 5'(i % 7 + 1));
        #2 rstn = 1'b1;
        #1;
        tests++;
        assert (res_rdy === 1'b0 && merchant === 8'd0 && remainder === 5'd0) else begin
            fails++;
            $error("FAIL async_reset: got rdy=%b q=%0d r=%0d required 0,0,0", res_rdy, merchant, remainder);
        end
        q.delete();
        last_m = '0;
        last_r = '0;
        step(1'b0, 8'd0, 5'd0);
        step(1'b0, 8'd0, 5'd0);
        rstn = 1'b0;
        step(1'b1, 8'd123, 5'd10);
        repeat (N + 3) step(1'b0, 8'd0, 5'd0);

        tests++;
        assert (q.size() == 0) else begin
            fails++;
            $error("FAIL drain: got %0d results outstanding required 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
